// File: rtl/md_sequencer.sv
// Multiply/divide-aware instruction sequencer: issues single-cycle ALU/shift/HI-LO moves
// and steps MULTU/DIVU through LOAD, ITER iterate cycles and a HI/LO write.
module md_sequencer #(
    parameter int unsigned ITER = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [5:0] req_funct,
    output logic       req_ready,
    output logic [5:0] op_out,
    output logic [1:0] out_sel,
    output logic       md_load,
    output logic       mul_en,
    output logic       div_en,
    output logic       hilo_we,
    output logic [5:0] iter_cnt,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSlt   = 6'h2A;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMflo  = 6'h12;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDivu  = 6'h1B;

    localparam logic [5:0] IterLast = 6'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StWrite} state_e;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [1:0] sel_q, sel_d;
    logic [5:0] iter_q, iter_d;
    logic       md_load_q, md_load_d;
    logic       mul_en_q, mul_en_d;
    logic       div_en_q, div_en_d;
    logic       hilo_we_q, hilo_we_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    logic       is_single, is_md, accept;
    logic [1:0] sel_dec;

    always_comb begin
        is_single = 1'b1;
        is_md     = 1'b0;
        sel_dec   = 2'b00;
        case (req_funct)
            FnAnd, FnOr, FnAdd, FnSub, FnSlt: sel_dec = 2'b00;
            FnSrl:                            sel_dec = 2'b01;
            FnMfhi:                           sel_dec = 2'b10;
            FnMflo:                           sel_dec = 2'b11;
            FnMultu, FnDivu: begin
                is_single = 1'b0;
                is_md     = 1'b1;
            end
            default:                          is_single = 1'b0;
        endcase
    end

    // The edge that ends WRITE may also take the next request.
    assign accept = req_valid && (state_q == StIdle || state_q == StWrite);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sel_d     = sel_q;
        iter_d    = iter_q;
        busy_d    = busy_q;
        md_load_d = 1'b0;
        mul_en_d  = 1'b0;
        div_en_d  = 1'b0;
        hilo_we_d = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            StLoad: begin
                state_d  = StRun;
                iter_d   = 6'd0;
                mul_en_d = (op_q == FnMultu);
                div_en_d = (op_q == FnDivu);
            end
            StRun: begin
                if (iter_q == IterLast) begin
                    state_d   = StWrite;
                    iter_d    = 6'd0;
                    hilo_we_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    iter_d   = iter_q + 6'd1;
                    mul_en_d = mul_en_q;
                    div_en_d = div_en_q;
                end
            end
            StWrite: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                iter_d  = 6'd0;
            end
            default: ;
        endcase

        if (accept) begin
            if (is_single) begin
                op_d   = req_funct;
                sel_d  = sel_dec;
                done_d = 1'b1;
            end else if (is_md) begin
                op_d      = req_funct;
                state_d   = StLoad;
                md_load_d = 1'b1;
                busy_d    = 1'b1;
                iter_d    = 6'd0;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 6'd0;
            sel_q     <= 2'b00;
            iter_q    <= 6'd0;
            md_load_q <= 1'b0;
            mul_en_q  <= 1'b0;
            div_en_q  <= 1'b0;
            hilo_we_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sel_q     <= sel_d;
            iter_q    <= iter_d;
            md_load_q <= md_load_d;
            mul_en_q  <= mul_en_d;
            div_en_q  <= div_en_d;
            hilo_we_q <= hilo_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign op_out    = op_q;
    assign out_sel   = sel_q;
    assign iter_cnt  = iter_q;
    assign md_load   = md_load_q;
    assign mul_en    = mul_en_q;
    assign div_en    = div_en_q;
    assign hilo_we   = hilo_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized and directed bench for md_sequencer against a timeline-based reference model.
module tb_md_sequencer;

    localparam int ITER = 32;

    logic       clk, rst, req_valid;
    logic [5:0] req_funct;
    logic       req_ready, md_load, mul_en, div_en, hilo_we, busy, done, illegal;
    logic [5:0] op_out, iter_cnt;
    logic [1:0] out_sel;

    int checks = 0;
    int errors = 0;

    md_sequencer #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct(req_funct),
        .req_ready(req_ready), .op_out(op_out), .out_sel(out_sel), .md_load(md_load),
        .mul_en(mul_en), .div_en(div_en), .hilo_we(hilo_we), .iter_cnt(iter_cnt),
        .busy(busy), .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_k counts cycles since a multicycle accept (0 = none in flight).
    int         m_k;
    logic [5:0] m_op;
    logic [1:0] m_sel;
    logic       m_done, m_ill;

    logic [5:0] legal_fn [10] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A,
                                  6'h02, 6'h10, 6'h12, 6'h19, 6'h1B};

    task automatic model_reset();
        m_k = 0; m_op = 6'd0; m_sel = 2'b00; m_done = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [5:0] f);
        m_done = 1'b0;
        m_ill  = 1'b0;
        if (m_k != 0 && m_k < ITER + 2) begin
            m_k++;
        end else begin
            m_k = 0;
            if (v) begin
                if (f == 6'h19 || f == 6'h1B) begin
                    m_op = f;
                    m_k  = 1;
                end else if (f == 6'h24 || f == 6'h25 || f == 6'h20 || f == 6'h22 ||
                             f == 6'h2A) begin
                    m_op = f; m_sel = 2'b00; m_done = 1'b1;
                end else if (f == 6'h02) begin
                    m_op = f; m_sel = 2'b01; m_done = 1'b1;
                end else if (f == 6'h10) begin
                    m_op = f; m_sel = 2'b10; m_done = 1'b1;
                end else if (f == 6'h12) begin
                    m_op = f; m_sel = 2'b11; m_done = 1'b1;
                end else begin
                    m_ill = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [21:0] exp_vec();
        logic run, wr;
        logic [5:0] it;
        run = (m_k >= 2) && (m_k <= ITER + 1);
        wr  = (m_k == ITER + 2);
        it  = run ? 6'(m_k - 2) : 6'd0;
        return {m_k == 0, m_op, m_sel, m_k == 1, run && (m_op == 6'h19),
                run && (m_op == 6'h1B), wr, it, m_k != 0, m_done || wr, m_ill};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {req_ready, op_out, out_sel, md_load, mul_en, div_en, hilo_we, iter_cnt,
                busy, done, illegal};
    endfunction

    task automatic cycle(input logic v, input logic [5:0] f);
        req_valid = v;
        req_funct = f;
        @(posedge clk);
        model_step(v, f);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_funct = 6'h20;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (obs_vec() !== 22'h200000) begin
            errors++; $display("FAIL reset act=%h exp=%h", obs_vec(), 22'h200000);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
    endtask

    task automatic test_add();
        cycle(1'b1, 6'h20);
        if (obs_vec() !== exp_vec() || op_out !== 6'h20 || done !== 1'b1) begin
            errors++; $display("FAIL add_issue act=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        cycle(1'b0, 6'h00);
        if (obs_vec() !== exp_vec() || done !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL add_after act=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_multu();
        int n_ld = 0, n_mul = 0, n_div = 0, n_busy = 0, done_at = 0;
        for (int i = 1; i <= ITER + 2; i++) begin
            cycle(i == 1, (i == 1) ? 6'h19 : 6'h00);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL multu_cyc%0d act=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            n_ld += int'(md_load); n_mul += int'(mul_en); n_div += int'(div_en);
            n_busy += int'(!req_ready);
            if (done && hilo_we) done_at = i;
        end
        if (n_ld !== 1 || n_mul !== ITER || n_div !== 0 || n_busy !== ITER + 2 ||
            done_at !== ITER + 2) begin
            errors++;
            $display("FAIL multu_counts ld=%0d mul=%0d div=%0d notready=%0d done_at=%0d",
                     n_ld, n_mul, n_div, n_busy, done_at);
        end
        checks++;
        cycle(1'b0, 6'h00);
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL multu_idle act=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_held_request();
        int d_div = 0, d_add = 0;
        for (int i = 1; i <= ITER + 4; i++) begin
            cycle(1'b1, (i == 1) ? 6'h1B : 6'h20);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL held_cyc%0d act=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (done && hilo_we) d_div = i;
            if (done && !hilo_we && d_add == 0) d_add = i;
        end
        if (d_div !== ITER + 2 || d_add !== ITER + 3) begin
            errors++;
            $display("FAIL held_latency divu_done=%0d want %0d add_done=%0d want %0d",
                     d_div, ITER + 2, d_add, ITER + 3);
        end
        checks++;
        cycle(1'b0, 6'h00);
    endtask

    task automatic test_illegal();
        logic [5:0] prev_op;
        prev_op = op_out;
        cycle(1'b1, 6'h3F);
        if (obs_vec() !== exp_vec() || illegal !== 1'b1 || op_out !== m_op || done !== 1'b0) begin
            errors++; $display("FAIL illegal act=%h exp=%h prev_op=%h", obs_vec(), exp_vec(),
                               prev_op);
        end
        checks++;
        cycle(1'b0, 6'h00);
        if (obs_vec() !== exp_vec() || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_after act=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_abort();
        int guard = 0;
        cycle(1'b1, 6'h19);
        while (!(mul_en && iter_cnt == 6'd10) && guard < 50) begin
            cycle(1'b0, 6'h00);
            guard++;
        end
        if (guard >= 50) begin
            errors++; $display("FAIL abort_wait iter_cnt=%0d never reached 10", iter_cnt);
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (obs_vec() !== 22'h200000) begin
            errors++; $display("FAIL abort_async act=%h exp=%h", obs_vec(), 22'h200000);
        end
        checks++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ITER + 4; i++) begin
            cycle(1'b0, 6'h00);
            if (obs_vec() !== exp_vec() || hilo_we !== 1'b0) begin
                errors++; $display("FAIL abort_quiet%0d act=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        cycle(1'b1, 6'h12);
        if (obs_vec() !== exp_vec() || out_sel !== 2'b11 || done !== 1'b1) begin
            errors++; $display("FAIL abort_mflo act=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns [3] = '{6'h02, 6'h10, 6'h12};
        logic [1:0] sels [3] = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, fns[i]);
            if (obs_vec() !== exp_vec() || out_sel !== sels[i] || done !== 1'b1) begin
                errors++; $display("FAIL b2b_%0d act=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        cycle(1'b0, 6'h00);
        if (obs_vec() !== exp_vec() || done !== 1'b0) begin
            errors++; $display("FAIL b2b_end act=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_random();
        logic       v;
        logic [5:0] f;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) < 10) f = legal_fn[$urandom_range(0, 9)];
            else f = 6'($urandom);
            cycle(v, f);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_%0d act=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct = 6'h00;
        test_reset();
        test_add();
        test_multu();
        test_held_request();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
